bp_ctrl: RTL and testbench

Branch-prediction controller for the 4-entry 2-bit predictor table. Tracks every conditional branch (BEQ/BNE) from fetch to MEM-stage resolution in an in-order queue. Compares each prediction against the resolved outcome, drives the table's update port, and raises a one-cycle flush/redirect on a mispredict. Sits between the fetch stage, the predictor table and the hazard unit.

---
 rtl/bp_ctrl_if.sv | 27 ++
 rtl/bp_ctrl.sv | 122 ++++++++++++
 tb/tb_bp_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/bp_ctrl_if.sv
// Fetch/resolve/update signal bundle between the pipeline and bp_ctrl.
// master = pipeline side (drives branch events), slave = bp_ctrl.
interface bp_ctrl_if #(
    parameter int IDXW = 2
);
    logic            if_branch;
    logic [IDXW-1:0] if_index;
    logic            if_pred;
    logic            mem_branch;
    logic            mem_taken;
    logic            pipe_stall;
    logic            upd_en;
    logic [IDXW-1:0] upd_index;
    logic            upd_taken;
    logic            flush;
    logic            redirect_taken;

    modport master (
        output if_branch, if_index, if_pred, mem_branch, mem_taken, pipe_stall,
        input  upd_en, upd_index, upd_taken, flush, redirect_taken
    );

    modport slave (
        input  if_branch, if_index, if_pred, mem_branch, mem_taken, pipe_stall,
        output upd_en, upd_index, upd_taken, flush, redirect_taken
    );
endinterface

// File: rtl/bp_ctrl.sv
// Branch-prediction controller: in-order queue of in-flight branches, table update and mispredict flush.
// Latency: update/flush one cycle after MEM resolve; pipe_stall freezes push/pop. Optional counters: BP_STATS_EN.
// Backpressure: none; overflowing pushes are dropped and empty pops ignored, both set sticky err.
module bp_ctrl #(
    parameter int DEPTH = 4,
    parameter int IDXW  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    bp_ctrl_if.slave                 bus,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     err,
    output logic [15:0]              stat_branches,
    output logic [15:0]              stat_mispred
);
    localparam int PTRW = $clog2(DEPTH);

    typedef struct packed {
        logic [IDXW-1:0] index;
        logic            pred;
    } entry_t;

    typedef enum logic {RUN, RECOVER} state_t;

    state_t          state_q, state_d;
    entry_t          q [DEPTH];
    entry_t          head;
    logic [PTRW-1:0] wr_ptr, rd_ptr;
    logic [PTRW:0]   count;

    logic push_req, pop_req, pop_ok, pop_empty, mispred, full, push_ok, overflow;

    always_comb begin
        head      = q[rd_ptr];
        full      = (count == (PTRW+1)'(DEPTH));
        push_req  = bus.if_branch  & ~bus.pipe_stall & (state_q == RUN);
        pop_req   = bus.mem_branch & ~bus.pipe_stall & (state_q == RUN);
        pop_ok    = pop_req & (count != '0);
        pop_empty = pop_req & (count == '0);
        mispred   = pop_ok & (head.pred != bus.mem_taken);
        // A push alongside a mispredict is wrong-path and is discarded with the rest.
        push_ok   = push_req & ~mispred & (~full | pop_ok);
        overflow  = push_req & full & ~pop_ok;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (mispred) state_d = RECOVER;
            RECOVER: state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (push_ok) q[wr_ptr] <= '{index: bus.if_index, pred: bus.if_pred};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (mispred) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTRW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTRW'(1);
            if (push_ok && !pop_ok)      count <= count + (PTRW+1)'(1);
            else if (pop_ok && !push_ok) count <= count - (PTRW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.upd_en         <= 1'b0;
            bus.upd_index      <= '0;
            bus.upd_taken      <= 1'b0;
            bus.flush          <= 1'b0;
            bus.redirect_taken <= 1'b0;
            err                <= 1'b0;
        end else begin
            bus.upd_en <= pop_ok;
            bus.flush  <= mispred;
            if (pop_ok) begin
                bus.upd_index <= head.index;
                bus.upd_taken <= bus.mem_taken;
            end
            if (mispred)              bus.redirect_taken <= bus.mem_taken;
            if (overflow | pop_empty) err <= 1'b1;
        end
    end

    assign pending = count;

`ifdef BP_STATS_EN
    logic [15:0] br_cnt, mp_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt <= '0;
            mp_cnt <= '0;
        end else begin
            if (pop_ok  && br_cnt != 16'hFFFF) br_cnt <= br_cnt + 16'd1;
            if (mispred && mp_cnt != 16'hFFFF) mp_cnt <= mp_cnt + 16'd1;
        end
    end

    assign stat_branches = br_cnt;
    assign stat_mispred  = mp_cnt;
`else
    assign stat_branches = '0;
    assign stat_mispred  = '0;
`endif
endmodule

// File: tb/tb_bp_ctrl.sv
// Directed bench for bp_ctrl: vector table for the main sequence, hand-written corner sequences.
module tb_bp_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  pending;
    logic        err;
    logic [15:0] stat_branches, stat_mispred;
    int          n_tests = 0;
    int          n_fail  = 0;

    bp_ctrl_if #(.IDXW(2)) bus ();

    bp_ctrl #(.DEPTH(4), .IDXW(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .pending(pending), .err(err),
        .stat_branches(stat_branches), .stat_mispred(stat_mispred)
    );

    always #5 clk = ~clk;

    // expected bundle: {upd_en, upd_index, upd_taken, flush, redirect_taken, pending, err}
    typedef struct {
        logic       ib;
        logic [1:0] ii;
        logic       ip;
        logic       mb;
        logic       mt;
        logic       ps;
        logic [9:0] exp;
    } vec_t;

    function automatic logic [9:0] e(input logic en, input logic [1:0] idx, input logic tk,
                                     input logic fl, input logic rd, input logic [2:0] pd,
                                     input logic er);
        return {en, idx, tk, fl, rd, pd, er};
    endfunction

    function automatic logic [9:0] obs();
        return {bus.upd_en, bus.upd_index, bus.upd_taken, bus.flush, bus.redirect_taken, pending, err};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ib, input logic [1:0] ii, input logic ip,
                         input logic mb, input logic mt, input logic ps);
        @(negedge clk);
        bus.if_branch  = ib;
        bus.if_index   = ii;
        bus.if_pred    = ip;
        bus.mem_branch = mb;
        bus.mem_taken  = mt;
        bus.pipe_stall = ps;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.if_branch = 1'b0; bus.if_index = '0; bus.if_pred = 1'b0;
        bus.mem_branch = 1'b0; bus.mem_taken = 1'b0; bus.pipe_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t tbl [16];

    initial begin
        tbl[0]  = '{1, 2'd2, 1, 0, 0, 0, e(0, 2'd0, 0, 0, 0, 3'd1, 0)};
        tbl[1]  = '{0, 2'd0, 0, 0, 0, 0, e(0, 2'd0, 0, 0, 0, 3'd1, 0)};
        tbl[2]  = '{0, 2'd0, 0, 1, 1, 0, e(1, 2'd2, 1, 0, 0, 3'd0, 0)};
        tbl[3]  = '{0, 2'd0, 0, 0, 0, 0, e(0, 2'd2, 1, 0, 0, 3'd0, 0)};
        tbl[4]  = '{1, 2'd1, 0, 0, 0, 0, e(0, 2'd2, 1, 0, 0, 3'd1, 0)};
        tbl[5]  = '{1, 2'd3, 1, 0, 0, 0, e(0, 2'd2, 1, 0, 0, 3'd2, 0)};
        // mispredict with a same-cycle push that must be discarded
        tbl[6]  = '{1, 2'd0, 0, 1, 1, 0, e(1, 2'd1, 1, 1, 1, 3'd0, 0)};
        // RECOVER cycle: push and pop ignored, no empty-pop error
        tbl[7]  = '{1, 2'd2, 1, 1, 0, 0, e(0, 2'd1, 1, 0, 1, 3'd0, 0)};
        tbl[8]  = '{1, 2'd1, 1, 0, 0, 0, e(0, 2'd1, 1, 0, 1, 3'd1, 0)};
        tbl[9]  = '{1, 2'd2, 0, 0, 0, 0, e(0, 2'd1, 1, 0, 1, 3'd2, 0)};
        tbl[10] = '{1, 2'd3, 1, 1, 1, 0, e(1, 2'd1, 1, 0, 1, 3'd2, 0)};
        tbl[11] = '{1, 2'd0, 1, 1, 1, 1, e(0, 2'd1, 1, 0, 1, 3'd2, 0)};
        tbl[12] = '{0, 2'd0, 0, 1, 0, 0, e(1, 2'd2, 0, 0, 1, 3'd1, 0)};
        tbl[13] = '{0, 2'd0, 0, 1, 1, 0, e(1, 2'd3, 1, 0, 1, 3'd0, 0)};
        tbl[14] = '{0, 2'd0, 0, 1, 0, 0, e(0, 2'd3, 1, 0, 1, 3'd0, 1)};
        tbl[15] = '{0, 2'd0, 0, 0, 0, 0, e(0, 2'd3, 1, 0, 1, 3'd0, 1)};

        do_reset();
        #1;
        chk("reset_outputs", 32'(obs()), 32'(e(0, 2'd0, 0, 0, 0, 3'd0, 0)));
        chk("reset_stats", {stat_branches, stat_mispred}, 32'd0);

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].ib, tbl[i].ii, tbl[i].ip, tbl[i].mb, tbl[i].mt, tbl[i].ps);
            chk($sformatf("vec%0d", i), 32'(obs()), 32'(tbl[i].exp));
        end

        // Overflow: five pushes into a four-deep queue, then in-order drain.
        do_reset();
        for (int i = 0; i < 5; i++) drive(1, 2'(i), i[0], 0, 0, 0);
        chk("ovf_pending", 32'(pending), 32'd4);
        chk("ovf_err", 32'(err), 32'd1);
        for (int i = 0; i < 4; i++) begin
            drive(0, 2'd0, 0, 1, i[0], 0);
            chk($sformatf("drain%0d_idx", i), {31'd0, bus.upd_en} << 8 | 32'(bus.upd_index),
                (32'd1 << 8) | 32'(i));
            chk($sformatf("drain%0d_flush", i), 32'(bus.flush), 32'd0);
        end
        chk("drain_pending", 32'(pending), 32'd0);

        // Counters: three correct pops then one wrong pop.
        do_reset();
        drive(1, 2'd0, 1, 0, 0, 0);
        drive(1, 2'd1, 0, 0, 0, 0);
        drive(1, 2'd2, 1, 0, 0, 0);
        drive(1, 2'd3, 1, 0, 0, 0);
        drive(0, 2'd0, 0, 1, 1, 0);
        drive(0, 2'd0, 0, 1, 0, 0);
        drive(0, 2'd0, 0, 1, 1, 0);
        drive(0, 2'd0, 0, 1, 0, 0);
        chk("stats_flush", {30'd0, bus.flush, bus.redirect_taken}, 32'd2);
`ifdef BP_STATS_EN
        chk("stats_counts", {stat_branches, stat_mispred}, {16'd4, 16'd1});
`else
        chk("stats_tied_off", {stat_branches, stat_mispred}, 32'd0);
`endif

        // Reset asserted while an update strobe is live.
        do_reset();
        drive(1, 2'd3, 1, 0, 0, 0);
        drive(1, 2'd2, 1, 1, 1, 0);
        chk("pre_rst", 32'(obs()), 32'(e(1, 2'd3, 1, 0, 0, 3'd1, 0)));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst", 32'(obs()), 32'(e(0, 2'd0, 0, 0, 0, 3'd0, 0)));
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_branch = 1'b0; bus.if_branch = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst", 32'(obs()), 32'(e(0, 2'd0, 0, 0, 0, 3'd0, 0)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
